conv_encoder_stream: RTL

Parametrised streaming convolutional encoder with valid/ready handshakes on input and output, run-time selectable code rate and constraint length, and automatic zero-tail trellis termination. It sits in front of the channel model / Viterbi decoder path in the endec datapath. It replaces the fixed single-bit encoder path with a back-pressurable, frame-aware stream that sustains one encoded word per cycle.

---
 rtl/conv_encoder_stream.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/conv_encoder_stream.sv
// Streaming convolutional encoder with valid/ready handshakes on both sides.
// Rate (1/2 or 1/3) and constraint length (3/5/7/9) are sampled while idle and
// latched on the first accepted bit of a frame. Every frame is closed with K-1
// zero tail bits, so the trellis always ends back in the all-zero state.
//
// Ports:
//   sys_clk, rst        clock, asynchronous active-low reset
//   en                  global enable for new input/tail beats
//   i_code_rate         0: rate 1/2, 1: rate 1/3
//   i_constr_len        00: K=3, 01: K=5, 10: K=7, 11: K=9
//   i_gen_poly_flat     generator j at [j*MAX_K +: MAX_K], bit i taps u delayed i cycles
//   s_valid/s_ready     input handshake, s_bit data, s_last end of frame
//   m_valid/m_ready     output handshake, m_data code word, m_tail/m_last beat flags
//   o_busy              frame in progress
//   o_frame_cnt         completed frame count (wraps)
module conv_encoder_stream #(
    parameter int unsigned MAX_K = 9,
    parameter int unsigned MAX_N = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   i_code_rate,
    input  logic [1:0]             i_constr_len,
    input  logic [MAX_N*MAX_K-1:0] i_gen_poly_flat,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_bit,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [MAX_N-1:0]       m_data,
    output logic                   m_tail,
    output logic                   m_last,
    output logic                   o_busy,
    output logic [CNT_W-1:0]       o_frame_cnt
);

    localparam int unsigned TCW = $clog2(MAX_K);

    typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

    state_e                 state_q, state_d;
    logic [MAX_K-2:0]       sr_q;
    logic                   rate_q;
    logic [1:0]             len_q;
    logic [MAX_N*MAX_K-1:0] poly_q;
    logic [TCW-1:0]         tail_cnt_q;
    logic                   m_valid_q, m_tail_q, m_last_q;
    logic [MAX_N-1:0]       m_data_q;
    logic [CNT_W-1:0]       frame_cnt_q;

    logic                   rate_sel;
    logic [1:0]             len_sel;
    logic [MAX_N*MAX_K-1:0] poly_sel;
    logic [3:0]             k_eff;
    logic [MAX_K-1:0]       k_mask;
    logic [MAX_K-1:0]       x;
    logic [MAX_N-1:0]       code;
    logic                   free, accept, tail_step, step, done, u;

    // Live config while idle so the first bit of a frame already uses it.
    always_comb begin
        rate_sel = rate_q;
        len_sel  = len_q;
        poly_sel = poly_q;
        if (state_q == StIdle) begin
            rate_sel = i_code_rate;
            len_sel  = i_constr_len;
            poly_sel = i_gen_poly_flat;
        end
        k_eff = {1'b0, len_sel, 1'b0} + 4'd3;
        for (int unsigned i = 0; i < MAX_K; i++) begin
            k_mask[i] = (i < 32'(k_eff));
        end
    end

    always_comb begin
        free      = !m_valid_q || m_ready;
        s_ready   = rst && en && (state_q != StTail) && free;
        accept    = s_valid && s_ready;
        tail_step = en && (state_q == StTail) && free && (tail_cnt_q != '0);
        step      = accept || tail_step;
        // Frame closes only once the final tail beat has been handed off.
        done      = (state_q == StTail) && m_valid_q && m_ready && m_last_q;
        u         = accept ? s_bit : 1'b0;
        x         = {sr_q, u};
        for (int unsigned j = 0; j < MAX_N; j++) begin
            code[j] = (j < (rate_sel ? 32'd3 : 32'd2)) ?
                      ^(poly_sel[j*MAX_K +: MAX_K] & x & k_mask) : 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = s_last ? StTail : StData;
            StData:  if (accept && s_last) state_d = StTail;
            StTail:  if (done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            rate_q      <= 1'b0;
            len_q       <= '0;
            poly_q      <= '0;
            tail_cnt_q  <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_tail_q    <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && accept) begin
                rate_q <= i_code_rate;
                len_q  <= i_constr_len;
                poly_q <= i_gen_poly_flat;
            end
            if (done) begin
                sr_q <= '0;
            end else if (step) begin
                sr_q <= {sr_q[MAX_K-3:0], u};
            end
            if (accept && s_last) begin
                tail_cnt_q <= TCW'(k_eff - 4'd1);
            end else if (tail_step) begin
                tail_cnt_q <= tail_cnt_q - 1'b1;
            end
            if (step) begin
                m_valid_q <= 1'b1;
                m_data_q  <= code;
                m_tail_q  <= tail_step;
                m_last_q  <= tail_step && (tail_cnt_q == TCW'(1));
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (done) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_tail      = m_tail_q;
    assign m_last      = m_last_q;
    assign o_busy      = (state_q != StIdle);
    assign o_frame_cnt = frame_cnt_q;

endmodule
